// File: rtl/fetch_pkg.sv
// Shared types and helpers for the instruction fetch sequencer: FSM state
// encoding, maximum instruction size and opcode length decode.
package fetch_pkg;

    localparam int MAX_BYTES = 3;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_FETCH   = 2'd1,
        ST_LOAD    = 2'd2,
        ST_PRESENT = 2'd3
    } state_t;

    // Instruction length in bytes, encoded in the top two opcode bits.
    function automatic logic [1:0] decode_len(input logic [7:0] opcode);
        case (opcode[7:6])
            2'b01:   decode_len = 2'd2;
            2'b10:   decode_len = 2'd3;
            default: decode_len = 2'd1;
        endcase
    endfunction

endpackage : fetch_pkg

// File: rtl/fetch_sequencer.sv
// Fetches a 1..3 byte instruction one byte at a time, streams it into the
// downstream 24-bit byte buffer, then holds it until the decoder accepts it.
module fetch_sequencer
    import fetch_pkg::*;
#(
    parameter logic [15:0] RESET_PC  = 16'h0000,
    parameter logic [7:0]  FILL_BYTE = 8'h00
) (
    input  logic        clk,
    input  logic        n_rst,
    input  logic        enable,
    input  logic        pc_load,
    input  logic [15:0] pc_load_addr,
    output logic        mem_req,
    output logic [15:0] mem_addr,
    input  logic [7:0]  mem_rdata,
    input  logic        mem_ack,
    output logic        shift_en,
    output logic [7:0]  new_instr,
    output logic        instr_valid,
    output logic [1:0]  instr_len,
    input  logic        instr_ready,
    output logic [15:0] pc
);

    localparam logic [1:0] LAST_SLOT = 2'(MAX_BYTES - 1);

    state_t      r_state;
    state_t      w_next_state;
    logic [15:0] r_pc;
    logic [1:0]  r_byte_idx;
    logic [1:0]  r_load_cnt;
    logic [1:0]  r_len;
    logic [7:0]  r_staging [MAX_BYTES];
    logic [1:0]  w_opcode_len;
    logic        w_last_byte;

    assign mem_addr  = r_pc;
    assign pc        = r_pc;
    assign instr_len = r_len;

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        // NOTE: every output gets a default before the case so no path can infer a latch.
        w_next_state = r_state;
        mem_req      = 1'b0;
        shift_en     = 1'b0;
        new_instr    = 8'h00;
        instr_valid  = 1'b0;
        w_opcode_len = decode_len(mem_rdata);
        w_last_byte  = 1'b0;

        case (r_state)
            ST_IDLE: begin
                if (enable) begin
                    w_next_state = ST_FETCH;
                end
            end
            ST_FETCH: begin
                mem_req = 1'b1;
                if (mem_ack) begin
                    // Byte 0 has no registered length yet, so decode it on the fly.
                    w_last_byte = (r_byte_idx == 2'd0) ? (w_opcode_len == 2'd1)
                                                       : (r_byte_idx + 2'd1 == r_len);
                    if (w_last_byte) begin
                        w_next_state = ST_LOAD;
                    end
                end
            end
            ST_LOAD: begin
                shift_en  = 1'b1;
                new_instr = (r_load_cnt < r_len) ? r_staging[r_load_cnt] : FILL_BYTE;
                if (r_load_cnt == LAST_SLOT) begin
                    w_next_state = ST_PRESENT;
                end
            end
            ST_PRESENT: begin
                instr_valid = 1'b1;
                if (instr_ready) begin
                    w_next_state = enable ? ST_FETCH : ST_IDLE;
                end
            end
            default: w_next_state = ST_IDLE;
        endcase

        if (pc_load) begin
            w_next_state = ST_IDLE;
        end
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            r_pc       <= RESET_PC;
            r_byte_idx <= 2'd0;
            r_load_cnt <= 2'd0;
            r_len      <= 2'd0;
            // NOTE: the staging bytes are few and must read as zero after reset, so they are reset like plain flops.
            for (int i = 0; i < MAX_BYTES; i++) begin
                r_staging[i] <= 8'h00;
            end
        end else if (pc_load) begin
            r_pc       <= pc_load_addr;
            r_byte_idx <= 2'd0;
            r_load_cnt <= 2'd0;
            for (int i = 0; i < MAX_BYTES; i++) begin
                r_staging[i] <= 8'h00;
            end
        end else begin
            case (r_state)
                ST_FETCH: begin
                    if (mem_ack) begin
                        r_staging[r_byte_idx] <= mem_rdata;
                        r_pc                  <= r_pc + 16'd1;
                        if (r_byte_idx == 2'd0) begin
                            r_len <= w_opcode_len;
                        end
                        r_byte_idx <= w_last_byte ? 2'd0 : r_byte_idx + 2'd1;
                    end
                end
                ST_LOAD: begin
                    r_load_cnt <= (r_load_cnt == LAST_SLOT) ? 2'd0 : r_load_cnt + 2'd1;
                end
                default: begin
                    r_byte_idx <= 2'd0;
                    r_load_cnt <= 2'd0;
                end
            endcase
        end
    end

endmodule : fetch_sequencer

// File: tb/tb_fetch_sequencer.sv
// Scoreboard bench for fetch_sequencer: a memory responder feeds bytes, the
// stimulus queues the expected presented instruction, a monitor checks it.
module tb_fetch_sequencer;

    localparam logic [15:0] RESET_PC  = 16'h0000;
    localparam logic [7:0]  FILL_BYTE = 8'h00;

    typedef struct {
        logic [23:0] word;
        logic [1:0]  len;
        logic [15:0] pc;
    } exp_t;

    logic        clk = 1'b0;
    logic        n_rst;
    logic        enable;
    logic        pc_load;
    logic [15:0] pc_load_addr;
    logic        mem_req;
    logic [15:0] mem_addr;
    logic [7:0]  mem_rdata;
    logic        mem_ack;
    logic        shift_en;
    logic [7:0]  new_instr;
    logic        instr_valid;
    logic [1:0]  instr_len;
    logic        instr_ready;
    logic [15:0] pc;

    int checks   = 0;
    int failures = 0;

    exp_t        exp_q [$];
    logic [7:0]  shift_q [$];
    logic [15:0] addr_log [$];
    logic [7:0]  mem [65536];
    int          waits  = 0;
    int          n_acks = 0;

    fetch_sequencer #(
        .RESET_PC  (RESET_PC),
        .FILL_BYTE (FILL_BYTE)
    ) dut (
        .clk          (clk),
        .n_rst        (n_rst),
        .enable       (enable),
        .pc_load      (pc_load),
        .pc_load_addr (pc_load_addr),
        .mem_req      (mem_req),
        .mem_addr     (mem_addr),
        .mem_rdata    (mem_rdata),
        .mem_ack      (mem_ack),
        .shift_en     (shift_en),
        .new_instr    (new_instr),
        .instr_valid  (instr_valid),
        .instr_len    (instr_len),
        .instr_ready  (instr_ready),
        .pc           (pc)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Memory responder: acks after 'waits' stall cycles, address must hold while stalled.
    initial begin : responder
        int          wait_cnt;
        logic [15:0] held;
        wait_cnt  = 0;
        held      = 16'h0000;
        mem_ack   = 1'b0;
        mem_rdata = 8'h00;
        forever begin
            @(negedge clk);
            mem_ack = 1'b0;
            if (mem_req) begin
                if (wait_cnt == 0) begin
                    held = mem_addr;
                end else begin
                    check("addr_stable", 32'(mem_addr), 32'(held));
                end
                if (wait_cnt == waits) begin
                    mem_ack   = 1'b1;
                    mem_rdata = mem[mem_addr];
                    addr_log.push_back(mem_addr);
                    n_acks++;
                    wait_cnt = 0;
                end else begin
                    wait_cnt++;
                end
            end else begin
                wait_cnt = 0;
            end
        end
    end

    // Monitor: collects shifted bytes and checks each newly presented instruction.
    initial begin : monitor
        logic        prev_valid;
        logic [23:0] got;
        exp_t        e;
        prev_valid = 1'b0;
        forever begin
            @(negedge clk);
            if (!n_rst) begin
                shift_q.delete();
                prev_valid = 1'b0;
            end else begin
                if (shift_en) begin
                    shift_q.push_back(new_instr);
                end
                if (instr_valid && !prev_valid) begin
                    if (exp_q.size() == 0) begin
                        check("unexpected_instr", 32'(instr_valid), 32'(1'b0));
                    end else begin
                        e   = exp_q.pop_front();
                        got = 24'h000000;
                        for (int i = 0; i < shift_q.size() && i < 3; i++) begin
                            got[23 - 8*i -: 8] = shift_q[i];
                        end
                        check("shift_count", 32'(shift_q.size()), 32'(3));
                        check("shifted_bytes", 32'(got), 32'(e.word));
                        check("instr_len", 32'(instr_len), 32'(e.len));
                        check("pc_at_present", 32'(pc), 32'(e.pc));
                    end
                    shift_q.delete();
                end
                prev_valid = instr_valid;
            end
        end
    end

    task automatic wait_valid(input int max_cycles, output int cycles);
        cycles = 0;
        while (!instr_valid && cycles < max_cycles) begin
            @(negedge clk);
            #1;
            cycles++;
        end
        if (!instr_valid) begin
            check("valid_timeout", 32'(instr_valid), 32'(1'b1));
        end
    endtask

    task automatic start_fetch();
        enable = 1'b1;
        @(negedge clk);
        #1;
        enable = 1'b0;
    endtask

    task automatic accept();
        instr_ready = 1'b1;
        @(negedge clk);
        #1;
        instr_ready = 1'b0;
        check("valid_drop", 32'(instr_valid), 32'(1'b0));
        check("idle_after_accept", 32'(mem_req), 32'(1'b0));
    endtask

    task automatic redirect(input logic [15:0] addr);
        pc_load      = 1'b1;
        pc_load_addr = addr;
        @(negedge clk);
        #1;
        pc_load = 1'b0;
        check("pc_after_load", 32'(pc), 32'(addr));
    endtask

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: bench did not finish in time");
        $fatal(1, "timeout");
    end

    initial begin : stimulus
        int cycles;
        int base_acks;

        n_rst        = 1'b0;
        enable       = 1'b0;
        pc_load      = 1'b0;
        pc_load_addr = 16'h0000;
        instr_ready  = 1'b0;

        mem[16'h0000] = 8'h8A; mem[16'h0001] = 8'h11; mem[16'h0002] = 8'h22;
        mem[16'h0003] = 8'h05; mem[16'h0004] = 8'h40; mem[16'h0005] = 8'h77;
        mem[16'hFFFF] = 8'h80;
        mem[16'h0010] = 8'h80; mem[16'h0011] = 8'h33; mem[16'h0012] = 8'h44;
        mem[16'h0200] = 8'h01;
        mem[16'h0201] = 8'h9C; mem[16'h0202] = 8'h01; mem[16'h0203] = 8'h02;

        repeat (2) @(negedge clk);
        #1;
        check("rst_pc", 32'(pc), 32'(RESET_PC));
        check("rst_mem_req", 32'(mem_req), 32'(1'b0));
        check("rst_shift_en", 32'(shift_en), 32'(1'b0));
        check("rst_instr_valid", 32'(instr_valid), 32'(1'b0));
        check("rst_instr_len", 32'(instr_len), 32'(2'd0));
        check("rst_new_instr", 32'(new_instr), 32'(8'h00));
        n_rst = 1'b1;
        @(negedge clk);
        #1;

        // Three-byte instruction, zero-wait memory.
        waits = 0;
        exp_q.push_back('{word: 24'h8A1122, len: 2'd3, pc: 16'h0003});
        start_fetch();
        wait_valid(20, cycles);
        accept();

        // One-byte instruction: latency, single transaction, fill bytes.
        base_acks = n_acks;
        exp_q.push_back('{word: 24'h050000, len: 2'd1, pc: 16'h0004});
        start_fetch();
        wait_valid(20, cycles);
        check("latency_1byte", 32'(cycles + 1), 32'(5));
        check("single_transaction", 32'(n_acks - base_acks), 32'(1));
        accept();

        // Two-byte instruction with three stall cycles per byte.
        waits = 3;
        exp_q.push_back('{word: 24'h407700, len: 2'd2, pc: 16'h0006});
        start_fetch();
        wait_valid(40, cycles);
        accept();
        waits = 0;

        // Fetch across the top of the address space.
        redirect(16'hFFFF);
        addr_log.delete();
        exp_q.push_back('{word: 24'h808A11, len: 2'd3, pc: 16'h0002});
        start_fetch();
        wait_valid(20, cycles);
        check("wrap_addr_count", 32'(addr_log.size()), 32'(3));
        if (addr_log.size() == 3) begin
            check("wrap_addr0", 32'(addr_log[0]), 32'(16'hFFFF));
            check("wrap_addr1", 32'(addr_log[1]), 32'(16'h0000));
            check("wrap_addr2", 32'(addr_log[2]), 32'(16'h0001));
        end
        accept();

        // Redirect on the same cycle as the second ack drops the instruction.
        redirect(16'h0010);
        base_acks = n_acks;
        start_fetch();
        cycles = 0;
        while (!(mem_ack && n_acks == base_acks + 2) && cycles < 20) begin
            @(negedge clk);
            #1;
            cycles++;
        end
        check("second_ack_seen", 32'(n_acks - base_acks), 32'(2));
        redirect(16'h0200);
        check("drop_mem_req", 32'(mem_req), 32'(1'b0));
        check("drop_shift_en", 32'(shift_en), 32'(1'b0));
        repeat (8) begin
            @(negedge clk);
            #1;
            check("drop_no_valid", 32'(instr_valid), 32'(1'b0));
        end
        addr_log.delete();
        exp_q.push_back('{word: 24'h010000, len: 2'd1, pc: 16'h0201});
        start_fetch();
        wait_valid(20, cycles);
        check("redirect_first_addr", 32'(addr_log.size() > 0 ? addr_log[0] : 16'hXXXX), 32'(16'h0200));
        accept();

        // Decoder stalls for ten cycles; enable low at acceptance returns to IDLE.
        exp_q.push_back('{word: 24'h9C0102, len: 2'd3, pc: 16'h0204});
        enable = 1'b1;
        wait_valid(20, cycles);
        repeat (10) begin
            @(negedge clk);
            #1;
            check("stall_valid", 32'(instr_valid), 32'(1'b1));
            check("stall_no_req", 32'(mem_req), 32'(1'b0));
        end
        enable = 1'b0;
        accept();
        @(negedge clk);
        #1;
        check("stay_idle", 32'(mem_req), 32'(1'b0));

        // Reset in the middle of a stalled fetch leaves nothing pending.
        waits = 3;
        start_fetch();
        check("fetch_started", 32'(mem_req), 32'(1'b1));
        n_rst = 1'b0;
        #1;
        check("async_rst_req", 32'(mem_req), 32'(1'b0));
        check("async_rst_pc", 32'(pc), 32'(RESET_PC));
        @(negedge clk);
        #1;
        n_rst = 1'b1;
        repeat (3) @(negedge clk);
        #1;
        check("post_rst_req", 32'(mem_req), 32'(1'b0));
        check("post_rst_valid", 32'(instr_valid), 32'(1'b0));

        check("scoreboard_drained", 32'(exp_q.size()), 32'(0));
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_fetch_sequencer

// File: doc/fetch_sequencer.md
FETCH_SEQUENCER -- requirements
Module: fetch_sequencer

Interface
REQ-001 Parameter RESET_PC, 16'h0000, pc value after reset.
REQ-002 Parameter FILL_BYTE, 8'h00, byte loaded into unused instruction slots.
REQ-003 clk  in  1  single clock; all state updates on rising edge.
REQ-004 n_rst  in  1  reset, asynchronous, active-low.
REQ-005 enable  in  1  permits starting a new instruction fetch.
REQ-006 pc_load  in  1  redirect request, one-cycle pulse.
REQ-007 pc_load_addr  in  16  redirect target.
REQ-008 mem_req  out  1  memory read request.
REQ-009 mem_addr  out  16  read address, equals pc.
REQ-010 mem_rdata  in  8  read data, valid when mem_ack=1.
REQ-011 mem_ack  in  1  read completion strobe.
REQ-012 shift_en  out  1  write strobe to downstream 24-bit byte buffer.
REQ-013 new_instr  out  8  byte presented to byte buffer.
REQ-014 instr_valid  out  1  buffer holds complete instruction.
REQ-015 instr_len  out  2  byte count of presented instruction (1..3).
REQ-016 instr_ready  in  1  decoder accepts instruction.
REQ-017 pc  out  16  address of next byte to fetch.

Function
REQ-018 Downstream buffer contract: while shift_en=1 it writes new_instr to bits [23:16], [15:8], [7:0] on consecutive cycles 0,1,2; shift_en=0 restarts its slot count; design SHALL honour this.
REQ-019 FSM states IDLE, FETCH, LOAD, PRESENT; IDLE->FETCH when enable=1; FETCH->LOAD after last byte acked; LOAD->PRESENT after exactly 3 shift_en cycles; PRESENT->FETCH (enable=1) or IDLE (enable=0) on instr_ready=1.
REQ-020 In FETCH, mem_req SHALL stay 1 with stable mem_addr until mem_ack=1; mem_rdata captured into staging byte k on the ack cycle.
REQ-021 Back-to-back fetch: after non-final ack, mem_req stays 1 and mem_addr=pc+1 the next cycle.
REQ-022 Length from byte 0 (opcode): opcode[7:6]=2'b01 -> 2, 2'b10 -> 3, else 1; instr_len registered with byte 0.
REQ-023 pc increments by 1 per acked byte, wrapping 16'hFFFF->16'h0000.
REQ-024 LOAD: shift_en=1 for 3 consecutive cycles, new_instr = staging bytes 0,1,2; bytes at index >= instr_len driven FILL_BYTE.
REQ-025 instr_valid=1 only in PRESENT, held until instr_ready=1; instr_ready outside PRESENT ignored.
REQ-026 mem_ack while mem_req=0 SHALL be ignored.
REQ-027 pc_load=1 in any state: next cycle state=IDLE, pc=pc_load_addr, mem_req=0, shift_en=0, instr_valid=0, staging discarded; pc_load wins over simultaneous mem_ack or instr_ready (ack data and handshake dropped).
REQ-028 enable=0 mid-instruction does not abort; it only blocks IDLE->FETCH and PRESENT->FETCH.
REQ-029 Latency: 1-byte instruction with zero-wait ack reaches instr_valid=1 on 5th cycle after leaving IDLE.

Reset
REQ-030 n_rst=0 asynchronously forces IDLE, pc=RESET_PC, mem_req=0, shift_en=0, instr_valid=0, instr_len=0, new_instr=0, staging=0.
REQ-031 Reset mid-FETCH or mid-LOAD SHALL leave no pending request after release.

Structure
REQ-032 Package fetch_pkg SHALL hold the state enum, length-decode function, MAX_BYTES=3.
REQ-033 No sub-module; the byte buffer is instantiated beside this block at top level.

Verification
REQ-034 Reset, enable=1, opcode 8'h8A,8'h11,8'h22, zero-wait ack -> shift_en 3 cycles bytes 8A,11,22; instr_valid=1, instr_len=3, pc=RESET_PC+3.
REQ-035 Opcode 8'h05 -> bytes 05,00,00 loaded, instr_len=1, only one mem_req transaction.
REQ-036 Opcode 8'h40 with 3 wait cycles per byte -> mem_addr stable during waits, instr_len=2, pc advances 2.
REQ-037 pc_load_addr=16'hFFFF, opcode 8'h80 -> fetch addresses FFFF,0000,0001; pc=16'h0002.
REQ-038 pc_load asserted same cycle as second mem_ack -> data dropped, instr_valid never asserted, next mem_addr=pc_load_addr.
REQ-039 instr_ready held 0 for 10 cycles in PRESENT -> instr_valid stays 1, mem_req stays 0; enable=0 at acceptance -> IDLE.
